serial_add: RTL and testbench
=============================

// Module: serial_add
// PURPOSE
// - Bit-serial N-bit unsigned adder, LSB first. The additive counterpart of the half_sub datapath.
// - Processes one bit per clock through a registered carry.
// - start/busy/done handshake. Used where area matters more than latency.
// - Its results serve as the reference for subtractor checks: (a-b)+b == a.
// PARAMETERS
// - WIDTH  4  operand/result width in bits; legal range 2..32
// PORTS
// - clk_i     in   1      clock, rising edge
// - rst_ni    in   1      synchronous reset, active-low
// - start_i   in   1      request; sampled only when block is ready (IDLE or DONE)
// - a_i       in   WIDTH  operand A; captured on accepted start
// - b_i       in   WIDTH  operand B; captured on accepted start
// - busy_o    out  1      1 while an addition is in progress (RUN)
// - done_o    out  1      1-cycle pulse: sum_o/carry_o just updated
// - sum_o     out  WIDTH  (A+B) mod 2^WIDTH; held until next done_o
// - carry_o   out  1      carry out of bit WIDTH-1; held with sum_o
// BEHAVIOUR
// - Reset (rst_ni=0 at rising edge):
//   - state=IDLE; busy_o=0, done_o=0, sum_o=0, carry_o=0.
//   - Internal shift regs, carry FF and bit counter cleared.
// - States: IDLE, RUN, DONE.
//   - IDLE: start_i=1 -> load a_i,b_i into shift regs, carry=0, cnt=0 -> RUN.
//   - RUN: each cycle
//     - s = a[0]^b[0]^c; c' = maj(a[0],b[0],c).
//     - s shifts into result reg MSB side; a,b shift right; cnt++.
//     - When cnt==WIDTH-1 -> DONE.
//   - DONE (exactly one cycle):
//     - done_o=1; sum_o<=result reg, carry_o<=final carry.
//     - These updates take effect on the edge entering DONE.
//     - start_i=1 -> reload -> RUN (back-to-back); else -> IDLE.
// - Latency: accepted start at edge E -> done_o high in cycle after edge E+WIDTH.
//   - busy_o high for WIDTH cycles.
//   - Throughput one add per WIDTH+1 cycles.
// - busy_o = (state==RUN), registered-state decode; done_o = (state==DONE).
// - start_i during RUN is ignored; operands are not re-sampled.
// - a_i/b_i may change freely after acceptance.
// - sum_o/carry_o keep the previous result during RUN; never partial.
// - Reset during RUN or DONE: abort, outputs to reset values next cycle, no done_o.
//   - Reset dominates start_i.
// - Overflow wraps: sum_o is the low WIDTH bits; carry_o is bit WIDTH of the true sum.
// - cnt width $clog2(WIDTH); no counter wrap occurs (exits RUN at WIDTH-1).
// STRUCTURE
// - serial_add_pkg: typedef enum logic [1:0] {IDLE,RUN,DONE} sadd_state_t;
//   localparam SADD_WIDTH_DEFAULT=4.
// - Sub-module full_add (a_i,b_i,c_i -> sum_o,carry_o):
//   - combinational, built from two half_add instances + OR.
//   - One instance in the RUN datapath.
// - Top: state reg, cnt, A/B/result shift regs, carry FF, output regs.
// TESTING (WIDTH=4; start pulsed 1 cycle at edge E)
// - a=3,b=5 -> done_o at E+4; sum_o=8, carry_o=0; busy_o high E+1..E+4 edges.
// - a=15,b=1 -> sum_o=0, carry_o=1.
// - a=15,b=15 -> sum_o=14, carry_o=1.
// - Busy lockout:
//   - a=2,b=2 started; start with a=7,b=7 at E+2 -> ignored, sum_o=4.
//   - Only one done_o pulse.
// - Reset mid-run: a=9,b=6 started, rst_ni=0 at E+2 -> all outputs 0, no done_o.
//   - A fresh start then yields 15, carry 0.
// - Back-to-back:
//   - start held high: 1+2 then 4+4 -> done_o at E+4 (sum 3), E+9 (sum 8).
//   - sum_o holds 3 during second RUN.
// - Exhaustive: all 256 (a,b) pairs vs a+b; also check (a-b mod16)+b == a.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sadd_state_t;

    localparam int SADD_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/serial_add_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
interface serial_add_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SADD_WIDTH_DEFAULT
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, sum_o, carry_o
    );

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, sum_o, carry_o
    );
endinterface

// File: rtl/serial_add_full_add.sv
// One-bit full adder: two half adders chained, carries merged by OR.
module serial_add_full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);
    logic s0;
    logic c0;
    logic c1;

    serial_add_half_add u_ha0 (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (s0),
        .carry_o (c0)
    );

    serial_add_half_add u_ha1 (
        .a_i     (s0),
        .b_i     (c_i),
        .sum_o   (sum_o),
        .carry_o (c1)
    );

    assign carry_o = c0 | c1;
endmodule

// File: rtl/serial_add_half_add.sv
// One-bit half adder, building block of the serial full adder.
module serial_add_half_add (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

// File: rtl/serial_add.sv
// Bit-serial unsigned adder, LSB first, one bit per clock through a registered carry.
// Results land in sum_o/carry_o only on entry to DONE, so they are never partial.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SADD_WIDTH_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    serial_add_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sadd_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic fa_s;
    logic fa_c;

    serial_add_full_add u_fa (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .c_i     (c_q),
        .sum_o   (fa_s),
        .carry_o (fa_c)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    a_d     = bus.a_i;
                    b_d     = bus.b_i;
                    res_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                c_d   = fa_c;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    carry_d = fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o  = (state_q == RUN);
    assign bus.done_o  = (state_q == DONE);
    assign bus.sum_o   = sum_q;
    assign bus.carry_o = carry_q;
endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add at WIDTH=4: latency, lockout, reset abort, back-to-back, exhaustive.
module tb_serial_add;
    import serial_add_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_ni;
    int   n_chk = 0;
    int   n_bad = 0;
    logic [W-1:0] prev_sum;
    logic         prev_carry;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Start at edge E, scramble operands afterwards, check every cycle up to IDLE again.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec, input string tag);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        for (int k = 0; k < W; k++) begin
            chk({tag, " busy"}, {31'd0, bus.busy_o}, 32'd1);
            chk({tag, " no_done"}, {31'd0, bus.done_o}, 32'd0);
            chk({tag, " hold_sum"}, {28'd0, bus.sum_o}, {28'd0, prev_sum});
            chk({tag, " hold_carry"}, {31'd0, bus.carry_o}, {31'd0, prev_carry});
            tick();
        end
        chk({tag, " done"}, {31'd0, bus.done_o}, 32'd1);
        chk({tag, " busy_off"}, {31'd0, bus.busy_o}, 32'd0);
        chk({tag, " sum"}, {28'd0, bus.sum_o}, {28'd0, es});
        chk({tag, " carry"}, {31'd0, bus.carry_o}, {31'd0, ec});
        prev_sum   = es;
        prev_carry = ec;
        tick();
        chk({tag, " done_pulse"}, {31'd0, bus.done_o}, 32'd0);
        chk({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] seen_sum;
        logic [W:0]   full;
        logic [W-1:0] d;

        rst_ni      = 1'b0;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        prev_sum    = '0;
        prev_carry  = 1'b0;
        tick();
        tick();
        chk("rst busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst done", {31'd0, bus.done_o}, 32'd0);
        chk("rst sum", {28'd0, bus.sum_o}, 32'd0);
        chk("rst carry", {31'd0, bus.carry_o}, 32'd0);
        rst_ni = 1'b1;
        tick();

        do_add(4'd3, 4'd5, 4'd8, 1'b0, "3+5");
        do_add(4'd15, 4'd1, 4'd0, 1'b1, "15+1");
        do_add(4'd15, 4'd15, 4'd14, 1'b1, "15+15");

        // Second start at E+2 lands while RUN and must be ignored.
        bus.a_i = 4'd2; bus.b_i = 4'd2; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.a_i = 4'd7; bus.b_i = 4'd7; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        ndone = 0;
        seen_sum = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done_o) begin
                ndone++;
                seen_sum = bus.sum_o;
            end
            tick();
        end
        chk("lockout pulses", ndone, 32'd1);
        chk("lockout sum", {28'd0, seen_sum}, 32'd4);
        chk("lockout carry", {31'd0, bus.carry_o}, 32'd0);
        prev_sum = 4'd4; prev_carry = 1'b0;

        // Reset at E+2 aborts the add; start held high checks reset dominance.
        bus.a_i = 4'd9; bus.b_i = 4'd6; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        rst_ni = 1'b0;
        bus.start_i = 1'b1;
        tick();
        chk("abort busy", {31'd0, bus.busy_o}, 32'd0);
        chk("abort done", {31'd0, bus.done_o}, 32'd0);
        chk("abort sum", {28'd0, bus.sum_o}, 32'd0);
        chk("abort carry", {31'd0, bus.carry_o}, 32'd0);
        bus.start_i = 1'b0;
        rst_ni = 1'b1;
        prev_sum = '0; prev_carry = 1'b0;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.done_o) ndone++;
            tick();
        end
        chk("abort no_done", ndone, 32'd0);
        do_add(4'd9, 4'd6, 4'd15, 1'b0, "9+6");

        // Back-to-back with start held: done after E+4 and after E+9.
        bus.a_i = 4'd1; bus.b_i = 4'd2; bus.start_i = 1'b1;
        tick();
        bus.a_i = 4'd4; bus.b_i = 4'd4;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("b2b run1 busy", {31'd0, bus.busy_o}, 32'd1);
        end
        tick();
        chk("b2b done1", {31'd0, bus.done_o}, 32'd1);
        chk("b2b sum1", {28'd0, bus.sum_o}, 32'd3);
        tick();
        bus.start_i = 1'b0;
        bus.a_i = '0; bus.b_i = '0;
        chk("b2b reload busy", {31'd0, bus.busy_o}, 32'd1);
        chk("b2b reload no_done", {31'd0, bus.done_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("b2b hold sum", {28'd0, bus.sum_o}, 32'd3);
            tick();
        end
        chk("b2b hold sum", {28'd0, bus.sum_o}, 32'd3);
        tick();
        chk("b2b done2", {31'd0, bus.done_o}, 32'd1);
        chk("b2b sum2", {28'd0, bus.sum_o}, 32'd8);
        chk("b2b carry2", {31'd0, bus.carry_o}, 32'd0);
        tick();
        chk("b2b end", {31'd0, bus.done_o}, 32'd0);
        prev_sum = 4'd8; prev_carry = 1'b0;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                full = 5'(a) + 5'(b);
                do_add(4'(a), 4'(b), full[W-1:0], full[W], "exh");
            end
        end

        // Subtract-then-add round trip must return a.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                d    = 4'(a) - 4'(b);
                full = 5'(d) + 5'(b);
                do_add(d, 4'(b), 4'(a), full[W], "sub_rt");
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
